// File: rtl/loader_pkg.sv
// Shared types and default sizes for the policy loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_TARGETS = 3;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_NB_PERIPH = 8;
  localparam int DEF_ID_W      = 3;

endpackage

// File: rtl/policy_loader_cksum.sv
// XOR accumulator over accepted words, compared against a reference latched at start.
// Only built when POLICY_LOADER_CHECKSUM_EN is defined.
`ifdef POLICY_LOADER_CHECKSUM_EN
module policy_loader_cksum #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] ref_i,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              check_i,
  output logic [DATA_W-1:0] cksum_o,
  output logic              mismatch_o
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_ref;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_ref <= '0;
    end else if (clear_i) begin
      r_acc <= '0;
      r_ref <= ref_i;
    end else if (accept_i) begin
      r_acc <= r_acc ^ data_i;
    end
  end

  assign cksum_o    = r_acc;
  assign mismatch_o = check_i && (r_acc != r_ref);

endmodule
`endif

// File: rtl/policy_loader.sv
// Streams DEPTH words into one of N_TARGETS policy memories, gated by load_ctrl_i[id].
// Optional POLICY_LOADER_CHECKSUM_EN adds cksum_i/cksum_o and an end-of-load XOR check.
module policy_loader
  import loader_pkg::*;
#(
  parameter int N_TARGETS = DEF_N_TARGETS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NB_PERIPH = DEF_NB_PERIPH,
  parameter int ID_W      = DEF_ID_W,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int SEL_W     = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [SEL_W-1:0]     target_sel_i,
  input  logic [ID_W-1:0]      id_i,
  input  logic                 abort_i,
  input  logic [NB_PERIPH-1:0] load_ctrl_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [N_TARGETS-1:0] wr_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
`ifdef POLICY_LOADER_CHECKSUM_EN
  ,
  input  logic [DATA_W-1:0]    cksum_i,
  output logic [DATA_W-1:0]    cksum_o
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_sel;
  logic [ID_W-1:0]      r_id;
  logic [ADDR_W-1:0]    r_count;
  logic [N_TARGETS-1:0] r_wr;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_err;

  logic w_start, w_bad_sel, w_abort, w_ready, w_accept, w_cksum_err;

  assign w_start   = (r_state == IDLE) && start_i;
  assign w_bad_sel = int'(target_sel_i) >= N_TARGETS;
  assign w_abort   = (r_state == LOAD) && abort_i;
  assign w_ready   = (r_state == LOAD) && load_ctrl_i[r_id];
  // Abort wins over a beat presented in the same cycle.
  assign w_accept  = w_ready && data_valid_i && !abort_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start && !w_bad_sel) w_state_nxt = LOAD;
      LOAD: begin
        if (abort_i)                             w_state_nxt = IDLE;
        else if (w_accept && (r_count == LAST))  w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_id    <= '0;
      r_count <= '0;
      r_wr    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= (w_start && w_bad_sel) || w_abort;
      r_wr    <= w_accept ? (N_TARGETS'(1) << r_sel) : '0;
      r_addr  <= w_accept ? r_count : '0;
      r_wdata <= w_accept ? data_i  : '0;
      if (w_start) begin
        r_sel   <= target_sel_i;
        r_id    <= id_i;
        r_count <= '0;
      end else if (w_abort) begin
        r_count <= '0;
      end else if (w_accept && (r_count != LAST)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

`ifdef POLICY_LOADER_CHECKSUM_EN
  policy_loader_cksum #(.DATA_W(DATA_W)) u_cksum (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (w_start),
    .ref_i     (cksum_i),
    .accept_i  (w_accept),
    .data_i    (data_i),
    .check_i   (r_state == DONE),
    .cksum_o   (cksum_o),
    .mismatch_o(w_cksum_err)
  );
`else
  assign w_cksum_err = 1'b0;
`endif

  assign data_ready_o = w_ready;
  assign wr_o         = r_wr;
  assign addr_o       = r_addr;
  assign wdata_o      = r_wdata;
  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);
  assign err_o        = r_err || w_cksum_err;

endmodule

// File: tb/tb_policy_loader.sv
// Directed self-checking bench for policy_loader (N_TARGETS=3, DEPTH=8, DATA_W=32).
// Define POLICY_LOADER_CHECKSUM_EN to also exercise the checksum option.
module tb_policy_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  sel;
  logic [2:0]  id;
  logic        abort;
  logic [7:0]  lctrl;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic [2:0]  wr;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        busy, done, err;
`ifdef POLICY_LOADER_CHECKSUM_EN
  logic [31:0] cksum_in;
  logic [31:0] cksum_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  policy_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .target_sel_i(sel),
    .id_i        (id),
    .abort_i     (abort),
    .load_ctrl_i (lctrl),
    .data_i      (data),
    .data_valid_i(valid),
    .data_ready_o(ready),
    .wr_o        (wr),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
`ifdef POLICY_LOADER_CHECKSUM_EN
    ,
    .cksum_i     (cksum_in),
    .cksum_o     (cksum_out)
`endif
  );

  // Issue a start in one cycle; leaves start low afterwards.
  task automatic issue_start(input logic [1:0] s, input logic [2:0] i);
    @(negedge clk);
    start = 1'b1; sel = s; id = i;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; sel = 0; id = 0; abort = 0; lctrl = 0; data = 0; valid = 0;
`ifdef POLICY_LOADER_CHECKSUM_EN
    cksum_in = 0;
`endif
    repeat (2) @(negedge clk);
    n_tests++;
    if ({wr, addr, wdata, busy, done, err, ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr=%b addr=%0d wdata=%h busy=%b done=%b err=%b ready=%b, want all 0",
               wr, addr, wdata, busy, done, err, ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_load();
    lctrl = 8'b0000_0100;
    issue_start(2'd1, 3'd2);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        n_tests++;
        if (wr !== 3'b010 || addr !== 3'(k-1) || wdata !== 32'h100 + 32'(k-1) || done !== (k == 8)) begin
          n_fail++;
          $display("FAIL full_write[%0d]: got wr=%b addr=%0d wdata=%h done=%b, want wr=010 addr=%0d wdata=%h done=%b",
                   k-1, wr, addr, wdata, done, k-1, 32'h100 + 32'(k-1), k == 8);
        end
      end
      if (k < 8) begin
        data = 32'h100 + 32'(k); valid = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL full_ready[%0d]: got ready=%b busy=%b, want 1 1", k, ready, busy);
        end
      end else valid = 1'b0;
      @(negedge clk);
    end
    n_tests++;
    if (busy !== 1'b0 || wr !== 3'b000 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_after: got busy=%b wr=%b done=%b err=%b, want 0", busy, wr, done, err);
    end
  endtask

  task automatic test_stall();
    int beat;
    lctrl = 8'b0000_0010;
    issue_start(2'd0, 3'd1);
    beat = 0;
    for (int c = 0; c < 12; c++) begin
      // cycles 3..5 have load_ctrl dropped while data is still offered
      if (c >= 3 && c <= 5) begin
        lctrl = 8'b0000_0000; data = 32'hDEAD; valid = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_ready[%0d]: got ready=%b, want 0", c, ready);
        end
      end else if (beat < 8) begin
        lctrl = 8'b0000_0010; data = 32'h200 + 32'(beat); valid = 1'b1;
        beat++;
      end else valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (c >= 3 && c <= 5) begin
        if (wr !== 3'b000 || addr !== 3'd0 || wdata !== 32'd0) begin
          n_fail++;
          $display("FAIL stall_nowrite[%0d]: got wr=%b addr=%0d wdata=%h, want 0", c, wr, addr, wdata);
        end
      end else if (c < 11) begin
        if (wr !== 3'b001 || addr !== 3'(beat-1) || wdata !== 32'h200 + 32'(beat-1) || done !== (beat == 8)) begin
          n_fail++;
          $display("FAIL stall_write[%0d]: got wr=%b addr=%0d wdata=%h done=%b, want wr=001 addr=%0d wdata=%h",
                   c, wr, addr, wdata, done, beat-1, 32'h200 + 32'(beat-1));
        end
      end else if (busy !== 1'b0 || wr !== 3'b000) begin
        n_fail++;
        $display("FAIL stall_end: got busy=%b wr=%b, want 0 000", busy, wr);
      end
    end
  endtask

  task automatic test_bad_target();
    @(negedge clk);
    start = 1'b1; sel = 2'd3; id = 3'd0;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || wr !== 3'b000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_target: got err=%b busy=%b wr=%b done=%b, want err=1 busy=0 wr=000 done=0", err, busy, wr, done);
    end
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_target_pulse: got err=%b busy=%b, want 0 0", err, busy);
    end
  endtask

  task automatic test_abort();
    lctrl = 8'b0000_0001;
    issue_start(2'd2, 3'd0);
    for (int k = 0; k < 4; k++) begin
      data = 32'h300 + 32'(k); valid = 1'b1;
      @(negedge clk);
    end
    abort = 1'b1; data = 32'hBAD; valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; valid = 1'b0;
    n_tests++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || wr !== 3'b000) begin
      n_fail++;
      $display("FAIL abort: got err=%b done=%b busy=%b wr=%b, want err=1 done=0 busy=0 wr=000", err, done, busy, wr);
    end
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pulse: got err=%b, want 0", err);
    end
    issue_start(2'd2, 3'd0);
    data = 32'h400; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n_tests++;
    if (wr !== 3'b100 || addr !== 3'd0 || wdata !== 32'h400) begin
      n_fail++;
      $display("FAIL abort_restart: got wr=%b addr=%0d wdata=%h, want wr=100 addr=0 wdata=400", wr, addr, wdata);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midload();
    lctrl = 8'b0000_1000;
    issue_start(2'd0, 3'd3);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; sel = 2'd2;
      data = 32'h500 + 32'(k); valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (wr !== 3'b001 || addr !== 3'(k) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_start_ignored[%0d]: got wr=%b addr=%0d busy=%b, want wr=001 addr=%0d busy=1", k, wr, addr, busy, k);
      end
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    n_tests++;
    if ({wr, addr, wdata, busy, done, err, ready} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: got wr=%b addr=%0d wdata=%h busy=%b done=%b err=%b ready=%b, want all 0",
               wr, addr, wdata, busy, done, err, ready);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_abort_ignored: got err=%b done=%b busy=%b, want 0", err, done, busy);
    end
  endtask

`ifdef POLICY_LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic corrupt);
    logic [31:0] x;
    x = 32'h0;
    for (int k = 0; k < 8; k++) x ^= 32'h600 + 32'(k * 3);
    lctrl = 8'b0001_0000;
    cksum_in = corrupt ? ~x : x;
    issue_start(2'd1, 3'd4);
    for (int k = 0; k < 8; k++) begin
      data = 32'h600 + 32'(k * 3); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    n_tests++;
    if (done !== 1'b1 || err !== corrupt || cksum_out !== x) begin
      n_fail++;
      $display("FAIL checksum(corrupt=%b): got done=%b err=%b cksum=%h, want done=1 err=%b cksum=%h",
               corrupt, done, err, cksum_out, corrupt, x);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_bad_target();
    test_abort();
    test_reset_midload();
`ifdef POLICY_LOADER_CHECKSUM_EN
    test_checksum(1'b0);
    test_checksum(1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
